pwm_comet_sequencer: RTL and testbench

Pattern controller for the multi-output PWM block. Drives the PWM duty-load interface (duty_cycle / duty_valid / duty_output) to produce a "comet" chaser: a head channel set to peak duty, trailing channels decaying by a fixed amount per step. Sits between the board-level switches and the PWM instance. It owns the per-channel duty shadow and rewrites all channels once per step. Run/oe remain driven directly from the top level.

---
 rtl/pwm_comet_sequencer_if.sv | 14 +
 rtl/pwm_comet_sequencer.sv | 133 +++++++++++++
 tb/tb_pwm_comet_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_comet_sequencer_if.sv
// Duty-load bus between the comet sequencer and the PWM block.
interface pwm_comet_sequencer_if #(
  parameter int DUTY_WIDTH = 8,
  parameter int NB_OUTPUTS = 16
);
  localparam int CH_W = $clog2(NB_OUTPUTS);

  logic [DUTY_WIDTH-1:0] duty_cycle;
  logic                  duty_valid;
  logic [CH_W-1:0]       duty_output;

  modport master (output duty_cycle, output duty_valid, output duty_output);
  modport slave  (input  duty_cycle, input  duty_valid, input  duty_output);
endinterface

// File: rtl/pwm_comet_sequencer.sv
// Comet chaser: once per step rewrites every PWM channel, head at peak duty,
// the rest decaying by a fixed amount. Disabling issues one all-zero sweep.
module pwm_comet_sequencer #(
  parameter int NB_OUTPUTS = 16,
  parameter int DUTY_WIDTH = 8,
  parameter int STEP_TICKS = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          dir,
  input  logic [DUTY_WIDTH-1:0]         peak,
  input  logic [DUTY_WIDTH-1:0]         decay,
  pwm_comet_sequencer_if.master         duty,
  output logic [$clog2(NB_OUTPUTS)-1:0] head,
  output logic                          busy
);
  localparam int CH_W   = $clog2(NB_OUTPUTS);
  localparam int TICK_W = $clog2(STEP_TICKS);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NB_OUTPUTS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, CLEAR} state_t;

  state_t                                 state_q;
  logic [TICK_W-1:0]                      tick_q;
  logic                                   pending_q;
  logic                                   en_q;
  logic [CH_W-1:0]                        ch_q;
  logic [CH_W-1:0]                        head_q;
  logic [DUTY_WIDTH-1:0]                  peak_q, decay_q;
  logic                                   dir_q;
  logic [NB_OUTPUTS-1:0][DUTY_WIDTH-1:0]  level_q;

  logic                  tick_term;
  logic                  start;
  logic [DUTY_WIDTH-1:0] peak_sel, decay_sel, lvl, new_d;
  logic [CH_W-1:0]       head_d;

  // The first channel of a sweep is written on the same edge the sweep is
  // accepted, so it uses the live peak/decay; later channels use the latches.
  always_comb begin
    tick_term = en && (state_q != CLEAR) && (tick_q == TICK_LAST);
    start     = (state_q == IDLE) && en && (pending_q || tick_term);
    peak_sel  = (state_q == IDLE) ? peak  : peak_q;
    decay_sel = (state_q == IDLE) ? decay : decay_q;
    lvl       = level_q[ch_q];
    if (ch_q == head_q)      new_d = peak_sel;
    else if (lvl > decay_sel) new_d = lvl - decay_sel;
    else                     new_d = '0;
    if (dir_q) head_d = (head_q == '0)      ? CH_LAST : head_q - CH_W'(1);
    else       head_d = (head_q == CH_LAST) ? '0      : head_q + CH_W'(1);
  end

  // Step timer, pending latch, sweep/clear FSM and registered duty bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      tick_q           <= '0;
      pending_q        <= 1'b0;
      en_q             <= 1'b0;
      ch_q             <= '0;
      head_q           <= '0;
      peak_q           <= '0;
      decay_q          <= '0;
      dir_q            <= 1'b0;
      level_q          <= '0;
      duty.duty_cycle  <= '0;
      duty.duty_valid  <= 1'b0;
      duty.duty_output <= '0;
      busy             <= 1'b0;
    end else begin
      en_q <= en;
      if (!en || state_q == CLEAR || tick_term) tick_q <= '0;
      else                                       tick_q <= tick_q + TICK_W'(1);
      if (tick_term) pending_q <= 1'b1;
      duty.duty_valid <= 1'b0;
      busy            <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            peak_q           <= peak;
            decay_q          <= decay;
            dir_q            <= dir;
            pending_q        <= 1'b0;
            level_q[ch_q]    <= new_d;
            duty.duty_cycle  <= new_d;
            duty.duty_output <= ch_q;
            duty.duty_valid  <= 1'b1;
            busy             <= 1'b1;
            ch_q             <= ch_q + CH_W'(1);
            state_q          <= SWEEP;
          end else if (en_q && !en) begin
            ch_q    <= '0;
            state_q <= CLEAR;
          end
        end
        SWEEP: begin
          level_q[ch_q]    <= new_d;
          duty.duty_cycle  <= new_d;
          duty.duty_output <= ch_q;
          duty.duty_valid  <= 1'b1;
          busy             <= 1'b1;
          if (ch_q == CH_LAST) begin
            ch_q    <= '0;
            head_q  <= head_d;
            state_q <= en ? IDLE : CLEAR;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        CLEAR: begin
          level_q[ch_q]    <= '0;
          duty.duty_cycle  <= '0;
          duty.duty_output <= ch_q;
          duty.duty_valid  <= 1'b1;
          busy             <= 1'b1;
          if (ch_q == CH_LAST) begin
            ch_q      <= '0;
            head_q    <= '0;
            pending_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign head = head_q;
endmodule

// File: tb/tb_pwm_comet_sequencer.sv
// Directed bench for the comet sequencer, 4 channels, 8-cycle step.
module tb_pwm_comet_sequencer;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int ST = 8;

  localparam int ACT_NONE = 0, ACT_PEAK = 1, ACT_EN_OFF = 2, ACT_RST = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          dir = 1'b0;
  logic [DW-1:0] peak  = 8'd200;
  logic [DW-1:0] decay = 8'd64;
  logic [1:0]    head;
  logic          busy;

  pwm_comet_sequencer_if #(.DUTY_WIDTH(DW), .NB_OUTPUTS(N)) duty_if ();

  pwm_comet_sequencer #(.NB_OUTPUTS(N), .DUTY_WIDTH(DW), .STEP_TICKS(ST)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .dir   (dir),
    .peak  (peak),
    .decay (decay),
    .duty  (duty_if),
    .head  (head),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until a strobe is visible; lat = cycles taken.
  task automatic wait_first(input string tag, output int lat);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!duty_if.duty_valid && lat < 60);
    if (!duty_if.duty_valid) chk({tag, " timeout"}, 0, 1);
  endtask

  // Check n consecutive strobes starting at the current one; optionally
  // disturb inputs while strobe act_at is on the bus.
  task automatic chk_run(input string tag, input int e0, input int e1,
                         input int e2, input int e3, input int n,
                         input int act_at, input int act);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s vld%0d", tag, i), int'(duty_if.duty_valid), 1);
      chk($sformatf("%s busy%0d", tag, i), int'(busy), 1);
      chk($sformatf("%s ch%0d", tag, i), int'(duty_if.duty_output), i);
      chk($sformatf("%s duty%0d", tag, i), int'(duty_if.duty_cycle), e[i]);
      if (i == act_at) begin
        case (act)
          ACT_PEAK:   peak = 8'd50;
          ACT_EN_OFF: en   = 1'b0;
          ACT_RST:    begin rst = 1'b0; dir = 1'b0; end
          default:    ;
        endcase
      end
      if (i < n - 1) cyc();
    end
  endtask

  task automatic chk_end(input string tag, input int exp_head);
    cyc();
    chk({tag, " vld_end"}, int'(duty_if.duty_valid), 0);
    chk({tag, " busy_end"}, int'(busy), 0);
    chk({tag, " head"}, int'(head), exp_head);
  endtask

  int exp_tab [6][4] = '{
    '{200,   0,   0,   0},
    '{136, 200,   0,   0},
    '{ 72, 136, 200,   0},
    '{  8,  72, 136, 200},
    '{200,   8,  72, 136},
    '{136, 200,   8,  72}
  };
  int exp_head [6] = '{1, 2, 3, 0, 1, 2};

  int dir_tab [5][4] = '{
    '{200,   0,   0,   0},
    '{136,   0,   0, 200},
    '{ 72,   0, 200, 136},
    '{  8, 200, 136,  72},
    '{200, 136,  72,   8}
  };
  int dir_head [5] = '{3, 2, 1, 0, 3};

  initial begin
    int lat;
    int seen;

    // Reset hold with en high: everything quiet.
    rst = 1'b0; en = 1'b1; dir = 1'b0; peak = 8'd200; decay = 8'd64;
    @(negedge clk);
    repeat (3) begin
      cyc();
      chk("rst duty", int'(duty_if.duty_cycle), 0);
      chk("rst vld", int'(duty_if.duty_valid), 0);
      chk("rst ch", int'(duty_if.duty_output), 0);
      chk("rst head", int'(head), 0);
      chk("rst busy", int'(busy), 0);
    end
    rst = 1'b1;

    // Six plain steps: decay trail and head wrap.
    for (int s = 0; s < 6; s++) begin
      string t;
      t = $sformatf("step%0d", s + 1);
      wait_first(t, lat);
      chk({t, " lat"}, lat, (s == 0) ? 8 : 4);
      chk_run(t, exp_tab[s][0], exp_tab[s][1], exp_tab[s][2], exp_tab[s][3], 4, -1, ACT_NONE);
      chk_end(t, exp_head[s]);
    end

    // Larger decay saturates the 72 level to 0.
    decay = 8'd100;
    wait_first("step7", lat);
    chk("step7 lat", lat, 4);
    chk_run("step7", 36, 100, 200, 0, 4, -1, ACT_NONE);
    chk_end("step7", 3);

    // Zero decay holds trailing levels.
    decay = 8'd0;
    wait_first("step8", lat);
    chk_run("step8", 36, 100, 200, 200, 4, -1, ACT_NONE);
    chk_end("step8", 0);

    // Peak change mid-sweep takes effect next sweep only.
    wait_first("step9", lat);
    chk_run("step9", 200, 100, 200, 200, 4, 1, ACT_PEAK);
    chk_end("step9", 1);
    wait_first("step10", lat);
    chk("step10 lat", lat, 4);
    chk_run("step10", 200, 50, 200, 200, 4, -1, ACT_NONE);
    chk_end("step10", 2);

    // Disable during the 2nd strobe: sweep finishes, then a zero sweep.
    peak = 8'd200; decay = 8'd64;
    wait_first("step11", lat);
    chk_run("step11", 136, 0, 200, 136, 4, 1, ACT_EN_OFF);
    cyc();
    chk_run("clear", 0, 0, 0, 0, 4, -1, ACT_NONE);
    chk_end("clear", 0);
    seen = 0;
    repeat (30) begin
      cyc();
      if (duty_if.duty_valid) seen++;
    end
    chk("off strobes", seen, 0);

    // Decreasing direction from reset.
    rst = 1'b0; dir = 1'b1; en = 1'b1; peak = 8'd200; decay = 8'd64;
    repeat (2) cyc();
    rst = 1'b1;
    for (int s = 0; s < 5; s++) begin
      string t;
      t = $sformatf("dir%0d", s + 1);
      wait_first(t, lat);
      chk({t, " lat"}, lat, (s == 0) ? 8 : 4);
      chk_run(t, dir_tab[s][0], dir_tab[s][1], dir_tab[s][2], dir_tab[s][3], 4, -1, ACT_NONE);
      chk_end(t, dir_head[s]);
    end

    // Reset on the 3rd strobe aborts the sweep outright.
    wait_first("rstmid", lat);
    chk_run("rstmid", 136, 72, 8, 200, 3, 2, ACT_RST);
    chk_end("rstmid", 0);
    seen = 0;
    repeat (3) begin
      cyc();
      if (duty_if.duty_valid) seen++;
    end
    chk("rstmid quiet", seen, 0);
    rst = 1'b1;
    wait_first("post", lat);
    chk("post lat", lat, 8);
    chk_run("post", 200, 0, 0, 0, 4, -1, ACT_NONE);
    chk_end("post", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
